gcm_ae_hw_1x8_hls_deadlock_report_ctrl: RTL and testbench
=========================================================

GCM_AE_HW_1X8_HLS_DEADLOCK_REPORT_CTRL -- requirements
Module: gcm_ae_hw_1x8_hls_deadlock_report_ctrl

Interface
REQ-001 Parameter THRESH, default 16, is the number of consecutive cycles with block high before a deadlock is declared; legal range 2..255.
REQ-002 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port block, input, 1 bit: aggregated block flag from the top-level deadlock monitor.
REQ-005 Port axis_block_sigs, input, 7 bits: per-channel AXIS block flags, sampled for the snapshot.
REQ-006 Port inst_idle_sigs, input, 7 bits: per-instance idle flags, sampled for the snapshot.
REQ-007 Port clear, input, 1 bit: single-cycle request to re-arm after a delivered report.
REQ-008 Port report_ready, input, 1 bit: consumer accepts the report.
REQ-009 Port report_valid, output, 1 bit: a report is pending.
REQ-010 Port report_chan, output, 7 bits: axis_block_sigs captured at declaration.
REQ-011 Port report_idle, output, 7 bits: inst_idle_sigs captured at declaration.
REQ-012 Port deadlock, output, 1 bit: sticky deadlock indicator.
REQ-013 Port episodes, output, 8 bits: count of delivered reports, saturating.
REQ-014 Port report_time, output, 32 bits: cycle stamp of declaration (see Configuration).

Function
REQ-015 FSM states: IDLE, WATCH, REPORT, LATCHED; the state and all outputs are registered.
REQ-016 IDLE: block=1 -> WATCH with run counter=1; otherwise stay in IDLE with counter=0.
REQ-017 WATCH: block=1 increments the counter; block=0 -> IDLE and clears the counter (glitch rejection).
REQ-018 WATCH: block=1 in the cycle the counter equals THRESH-1 -> REPORT. Timing: declaration occurs on the THRESH-th consecutive high cycle, and report_valid rises on the next edge.
REQ-019 On the WATCH->REPORT edge:
- report_chan is loaded from axis_block_sigs;
- report_idle is loaded from inst_idle_sigs;
- deadlock is set to 1.
REQ-020 REPORT: report_valid=1; report_chan and report_idle stay stable until the handshake.
REQ-021 REPORT: block falling does not withdraw the report.
REQ-022 REPORT: clear is ignored.
REQ-023 REPORT: report_valid=1 and report_ready=1 in the same cycle -> LATCHED; episodes increments, saturating at 255.
REQ-024 LATCHED: report_valid=0; deadlock stays 1; report_chan and report_idle hold their values.
REQ-025 LATCHED: clear=1 -> IDLE; deadlock clears to 0 and the counter to 0; episodes and the snapshots are retained.
REQ-026 clear asserted in IDLE or WATCH has no effect.
REQ-027 report_ready asserted outside REPORT has no effect.
REQ-028 The run counter is 8 bits and never wraps, because it leaves WATCH at THRESH-1.

Reset
REQ-029 reset=0 asynchronously forces the following, independent of clock:
- state to IDLE;
- counter to 0;
- report_valid, deadlock and episodes to 0;
- report_chan, report_idle and report_time to 0.
REQ-030 Reset asserted mid-REPORT drops report_valid immediately, and the pending report is lost.
REQ-031 Reset deassertion is used as-is; synchronising it is the integrator's responsibility.

Configuration
REQ-032 The macro is GCM_DEADLOCK_TIMESTAMP_EN.
REQ-033 With GCM_DEADLOCK_TIMESTAMP_EN defined:
- a 32-bit free-running cycle counter exists, reset to 0, incrementing every cycle and wrapping at 2^32;
- report_time captures its value on the WATCH->REPORT edge and holds it like report_chan.
REQ-034 With GCM_DEADLOCK_TIMESTAMP_EN undefined: the cycle counter is absent, report_time is tied to 0, and all other behaviour is identical.

Verification
REQ-035 Block pulse: block high 15 cycles then low, THRESH=16 -> no report_valid; state returns to IDLE; deadlock=0.
REQ-036 Sustained block: block high with axis_block_sigs=7'h41 and inst_idle_sigs=7'h3E -> report_valid=1 on the cycle after the 16th high cycle, with report_chan=7'h41, report_idle=7'h3E, deadlock=1.
REQ-037 Backpressure: in REPORT, hold report_ready=0 for 10 cycles while block drops and axis_block_sigs changes -> report_valid and the snapshots are stable; report_ready=1 -> episodes=1, report_valid=0 next cycle.
REQ-038 Clear: pulse clear in REPORT -> ignored; pulse clear in LATCHED -> deadlock=0, IDLE; a new 16-cycle block -> second report, episodes=2.
REQ-039 Reset in REPORT: drive reset=0 mid-cycle -> report_valid and deadlock go 0 before the next clock edge; after release, a new declaration works normally.
REQ-040 Timestamp (macro defined): declaration on cycle 100 after reset release -> report_time=100; macro undefined -> report_time=0.

Source files
------------

// File: rtl/gcm_ae_hw_1x8_hls_deadlock_report_ctrl.sv
// Deadlock report controller: declares a deadlock after THRESH consecutive block cycles and holds a snapshot report.
// Latency: report_valid rises on the edge after the THRESH-th consecutive high block cycle.
// Backpressure: the report is held stable in REPORT until report_ready; optional stamp via GCM_DEADLOCK_TIMESTAMP_EN.
module gcm_ae_hw_1x8_hls_deadlock_report_ctrl #(
    parameter int unsigned THRESH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        block,
    input  logic [6:0]  axis_block_sigs,
    input  logic [6:0]  inst_idle_sigs,
    input  logic        clear,
    input  logic        report_ready,
    output logic        report_valid,
    output logic [6:0]  report_chan,
    output logic [6:0]  report_idle,
    output logic        deadlock,
    output logic [7:0]  episodes,
    output logic [31:0] report_time
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WATCH   = 2'd1,
        S_REPORT  = 2'd2,
        S_LATCHED = 2'd3
    } state_t;

    // Last counter value seen in WATCH before the declaring cycle (THRESH is 2..255).
    localparam logic [7:0] LP_LAST = 8'(THRESH - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_report_valid;
    logic [6:0]  r_report_chan;
    logic [6:0]  r_report_idle;
    logic        r_deadlock;
    logic [7:0]  r_episodes;
    logic        w_declare;
    logic        w_handshake;

    // Declaration happens on the THRESH-th consecutive high cycle; delivery on valid&ready in REPORT.
    assign w_declare   = (r_state == S_WATCH) && block && (r_cnt == LP_LAST);
    assign w_handshake = (r_state == S_REPORT) && r_report_valid && report_ready;

    // Main FSM with all outputs registered alongside the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= 8'd0;
            r_report_valid <= 1'b0;
            r_report_chan  <= 7'd0;
            r_report_idle  <= 7'd0;
            r_deadlock     <= 1'b0;
            r_episodes     <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (block) begin
                        r_state <= S_WATCH;
                        r_cnt   <= 8'd1;
                    end else begin
                        r_cnt   <= 8'd0;
                    end
                end
                S_WATCH: begin
                    if (!block) begin
                        // A short stall is not a deadlock: drop back and restart the run.
                        r_state <= S_IDLE;
                        r_cnt   <= 8'd0;
                    end else if (w_declare) begin
                        r_state        <= S_REPORT;
                        r_report_valid <= 1'b1;
                        r_report_chan  <= axis_block_sigs;
                        r_report_idle  <= inst_idle_sigs;
                        r_deadlock     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_REPORT: begin
                    // block and clear are deliberately ignored so the report is never withdrawn.
                    if (w_handshake) begin
                        r_state        <= S_LATCHED;
                        r_report_valid <= 1'b0;
                        if (r_episodes != 8'hFF) begin
                            r_episodes <= r_episodes + 8'd1;
                        end
                    end
                end
                S_LATCHED: begin
                    // Re-arm only on explicit request; episode count and snapshots survive.
                    if (clear) begin
                        r_state    <= S_IDLE;
                        r_deadlock <= 1'b0;
                        r_cnt      <= 8'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

`ifdef GCM_DEADLOCK_TIMESTAMP_EN
    logic [31:0] r_cycle;
    logic [31:0] r_report_time;

    // Free-running cycle counter, wraps naturally at 2^32.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // Stamp the declaring cycle and hold it like the other snapshots.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_report_time <= 32'd0;
        end else if (w_declare) begin
            r_report_time <= r_cycle;
        end
    end

    assign report_time = r_report_time;
`else
    assign report_time = 32'd0;
`endif

    assign report_valid = r_report_valid;
    assign report_chan  = r_report_chan;
    assign report_idle  = r_report_idle;
    assign deadlock     = r_deadlock;
    assign episodes     = r_episodes;

endmodule

// File: tb/tb_gcm_ae_hw_1x8_hls_deadlock_report_ctrl.sv
// Bench for the deadlock report controller: directed stimulus with a report scoreboard.
// Expected reports are queued when block is raised; a negedge monitor checks each delivered report.
// Control-path checks (timing, deadlock, episodes, reset) are done inline by the stimulus.
module tb_gcm_ae_hw_1x8_hls_deadlock_report_ctrl;

    logic        clock;
    logic        reset;
    logic        block;
    logic [6:0]  axis_block_sigs;
    logic [6:0]  inst_idle_sigs;
    logic        clear;
    logic        report_ready;
    logic        report_valid;
    logic [6:0]  report_chan;
    logic [6:0]  report_idle;
    logic        deadlock;
    logic [7:0]  episodes;
    logic [31:0] report_time;

    typedef struct {
        logic [6:0]  chan;
        logic [6:0]  idle;
        logic [31:0] tstamp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          popped = 0;
    logic [31:0] tb_cyc;

    gcm_ae_hw_1x8_hls_deadlock_report_ctrl #(.THRESH(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .block           (block),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .clear           (clear),
        .report_ready    (report_ready),
        .report_valid    (report_valid),
        .report_chan     (report_chan),
        .report_idle     (report_idle),
        .deadlock        (deadlock),
        .episodes        (episodes),
        .report_time     (report_time)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycles elapsed since reset release, used only to predict the timestamp.
    always @(posedge clock or negedge reset) begin
        if (!reset) tb_cyc <= 32'd0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Declaration comes 16 edges after block is raised, stamping the value seen before that edge.
    function automatic logic [31:0] exp_stamp();
`ifdef GCM_DEADLOCK_TIMESTAMP_EN
        return tb_cyc + 32'd15;
`else
        return 32'd0;
`endif
    endfunction

    task automatic push(input logic [6:0] c, input logic [6:0] i);
        exp_t e;
        e.chan   = c;
        e.idle   = i;
        e.tstamp = exp_stamp();
        sb.push_back(e);
    endtask

    // Monitor: every accepted report must match the oldest queued expectation.
    always @(negedge clock) begin
        if (reset && report_valid && report_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_report actual=chan %0h required=no report", report_chan);
            end else begin
                exp_t e;
                e = sb.pop_front();
                popped++;
                chk("mon_chan", 32'(report_chan), 32'(e.chan));
                chk("mon_idle", 32'(report_idle), 32'(e.idle));
                chk("mon_time", report_time, e.tstamp);
                chk("mon_deadlock", 32'(deadlock), 32'd1);
            end
        end
    end

    initial begin
        int bad;
        reset           = 1'b0;
        block           = 1'b0;
        axis_block_sigs = 7'd0;
        inst_idle_sigs  = 7'd0;
        clear           = 1'b0;
        report_ready    = 1'b0;
        #12;
        chk("rst_valid", 32'(report_valid), 32'd0);
        chk("rst_deadlock", 32'(deadlock), 32'd0);
        chk("rst_episodes", 32'(episodes), 32'd0);
        chk("rst_chan", 32'(report_chan), 32'd0);
        chk("rst_idle", 32'(report_idle), 32'd0);
        chk("rst_time", report_time, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Block pulse of 15 cycles must not declare; clear in IDLE/WATCH has no effect.
        block = 1'b1;
        axis_block_sigs = 7'h7F;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        bad = 0;
        for (int k = 0; k < 14; k++) begin
            tick(1);
            if (report_valid !== 1'b0) bad++;
        end
        block = 1'b0;
        tick(1);
        if (report_valid !== 1'b0) bad++;
        chk("pulse_no_valid", 32'(bad), 32'd0);
        chk("pulse_deadlock", 32'(deadlock), 32'd0);
        chk("pulse_episodes", 32'(episodes), 32'd0);

        // Sustained block: report appears exactly after the 16th high cycle.
        axis_block_sigs = 7'h41;
        inst_idle_sigs  = 7'h3E;
        push(7'h41, 7'h3E);
        block = 1'b1;
        tick(15);
        chk("sus_valid_early", 32'(report_valid), 32'd0);
        tick(1);
        chk("sus_valid", 32'(report_valid), 32'd1);
        chk("sus_chan", 32'(report_chan), 32'h41);
        chk("sus_idle", 32'(report_idle), 32'h3E);
        chk("sus_deadlock", 32'(deadlock), 32'd1);

        // Backpressure: report stays put while block drops, inputs change and clear is pulsed.
        block = 1'b0;
        axis_block_sigs = 7'h12;
        inst_idle_sigs  = 7'h01;
        clear = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            clear = 1'b0;
            if (report_valid !== 1'b1 || report_chan !== 7'h41 || report_idle !== 7'h3E) bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        report_ready = 1'b1;
        tick(1);
        report_ready = 1'b0;
        chk("bp_valid_drop", 32'(report_valid), 32'd0);
        chk("bp_episodes", 32'(episodes), 32'd1);
        chk("latched_deadlock", 32'(deadlock), 32'd1);
        chk("latched_chan", 32'(report_chan), 32'h41);

        // Clear in LATCHED re-arms; a second declaration increments episodes.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clr_deadlock", 32'(deadlock), 32'd0);
        chk("clr_chan_kept", 32'(report_chan), 32'h41);
        chk("clr_episodes_kept", 32'(episodes), 32'd1);
        axis_block_sigs = 7'h2A;
        inst_idle_sigs  = 7'h55;
        push(7'h2A, 7'h55);
        block = 1'b1;
        tick(15);
        chk("second_valid_early", 32'(report_valid), 32'd0);
        tick(1);
        chk("second_valid", 32'(report_valid), 32'd1);
        report_ready = 1'b1;
        tick(1);
        report_ready = 1'b0;
        block = 1'b0;
        chk("second_episodes", 32'(episodes), 32'd2);

        // Reset mid-REPORT: outputs drop before the next clock edge.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        axis_block_sigs = 7'h0F;
        inst_idle_sigs  = 7'h70;
        block = 1'b1;
        tick(16);
        chk("pre_rst_valid", 32'(report_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 32'(report_valid), 32'd0);
        chk("async_rst_deadlock", 32'(deadlock), 32'd0);
        chk("async_rst_episodes", 32'(episodes), 32'd0);
        chk("async_rst_chan", 32'(report_chan), 32'd0);
        sb.delete();
        block = 1'b0;
        tick(1);
        reset = 1'b1;

        // Post-reset declaration timed to land on cycle 100.
        tick(85);
        axis_block_sigs = 7'h33;
        inst_idle_sigs  = 7'h4C;
        push(7'h33, 7'h4C);
        block = 1'b1;
        tick(16);
        chk("ts_valid", 32'(report_valid), 32'd1);
`ifdef GCM_DEADLOCK_TIMESTAMP_EN
        chk("ts_time", report_time, 32'd100);
`else
        chk("ts_time", report_time, 32'd0);
`endif
        report_ready = 1'b1;
        tick(1);
        report_ready = 1'b0;
        block = 1'b0;
        chk("ts_episodes", 32'(episodes), 32'd1);

        tick(2);
        chk("sb_popped", 32'(popped), 32'd3);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
